// File: rtl/uart_bridge_pkg.sv
// Shared constants, state encoding and decode helpers for the UART bus bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;

  localparam logic [7:0] DEF_ACK_BYTE = 8'hAA;
  localparam logic [7:0] DEF_ERR_BYTE = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_TX_B0,
    ST_TX_B1
  } state_t;

  // States that pop bytes from the receive FIFO.
  function automatic logic is_collecting(input state_t s);
    return (s == ST_IDLE) || (s == ST_ADDR_HI) || (s == ST_ADDR_LO) ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO);
  endfunction

  // States that mid-frame, where the inter-byte timeout applies.
  function automatic logic is_mid_frame(input state_t s);
    return (s == ST_ADDR_HI) || (s == ST_ADDR_LO) ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO);
  endfunction

endpackage

// File: rtl/uart_bridge_timer.sv
// Inter-byte timeout counter for the UART bus bridge. Counts idle cycles while
// enabled, clears on request, and saturates at LIMIT with expired held high.
module uart_bridge_timer #(
  parameter logic [15:0] LIMIT = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] count;

  assign expired = (count == LIMIT);

  // Idle-cycle counter; clear wins over count, and it stops at LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'h0;
    end else if (clr) begin
      count <= 16'h0;
    end else if (en && !expired) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command-frame to on-chip bus initiator.
// Write frame 01 AH AL DH DL -> ACK byte; read frame 02 AH AL -> two data bytes
// (high first); any other command byte -> ERR byte and a frame_err_o pulse.
// Optional feature: define UART_BRIDGE_TIMEOUT_EN to abort a frame that stalls
// for TIMEOUT_CYCLES between bytes.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0]  ERR_BYTE       = DEF_ERR_BYTE
) (
  input  logic        bus2ip_clk,
  input  logic        bus2ip_rst_n,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [15:0] bus2ip_addr_o,
  output logic [15:0] bus2ip_data_o,
  output logic        bus2ip_rd_ce_o,
  output logic        bus2ip_wr_ce_o,
  input  logic [15:0] ip2bus_data_i,
  output logic        frame_err_o
);

  state_t     state;
  logic       is_wr;
  logic [7:0] rdata_lo;
  logic       rx_fire;
  logic       tx_fire;
  logic       timeout;

  // NOTE: rx_ready_o is a state decode, so it is gated by reset to read 0
  // while reset is held rather than reflecting the IDLE reset state.
  assign rx_ready_o = bus2ip_rst_n && is_collecting(state);
  assign tx_valid_o = (state == ST_TX_B0) || (state == ST_TX_B1);
  assign rx_fire    = rx_valid_i && rx_ready_o;
  assign tx_fire    = tx_valid_o && tx_ready_i;

`ifdef UART_BRIDGE_TIMEOUT_EN
  uart_bridge_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (bus2ip_clk),
    .rst_n   (bus2ip_rst_n),
    .clr     (rx_fire || !is_mid_frame(state)),
    .en      (is_mid_frame(state)),
    .expired (timeout)
  );
`else
  logic [15:0] timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  // Frame FSM plus all registered outputs; strobes and frame_err default low
  // so each is a single-cycle pulse.
  always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
    if (!bus2ip_rst_n) begin
      state          <= ST_IDLE;
      is_wr          <= 1'b0;
      rdata_lo       <= 8'h00;
      tx_data_o      <= 8'h00;
      bus2ip_addr_o  <= 16'h0;
      bus2ip_data_o  <= 16'h0;
      bus2ip_rd_ce_o <= 1'b0;
      bus2ip_wr_ce_o <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register sees the
      // pre-edge values, independent of statement order.
      bus2ip_rd_ce_o <= 1'b0;
      bus2ip_wr_ce_o <= 1'b0;
      frame_err_o    <= 1'b0;

      if (is_mid_frame(state) && !rx_fire && timeout) begin
        state       <= ST_IDLE;
        frame_err_o <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_fire) begin
              if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
                is_wr <= (rx_data_i == CMD_WR);
                state <= ST_ADDR_HI;
              end else begin
                tx_data_o   <= ERR_BYTE;
                frame_err_o <= 1'b1;
                state       <= ST_TX_B1;
              end
            end
          end
          ST_ADDR_HI: begin
            if (rx_fire) begin
              bus2ip_addr_o[15:8] <= rx_data_i;
              state               <= ST_ADDR_LO;
            end
          end
          ST_ADDR_LO: begin
            if (rx_fire) begin
              bus2ip_addr_o[7:0] <= rx_data_i;
              if (is_wr) begin
                state <= ST_DATA_HI;
              end else begin
                bus2ip_rd_ce_o <= 1'b1;
                state          <= ST_BUS_RD;
              end
            end
          end
          ST_DATA_HI: begin
            if (rx_fire) begin
              bus2ip_data_o[15:8] <= rx_data_i;
              state               <= ST_DATA_LO;
            end
          end
          ST_DATA_LO: begin
            if (rx_fire) begin
              bus2ip_data_o[7:0] <= rx_data_i;
              bus2ip_wr_ce_o     <= 1'b1;
              state              <= ST_BUS_WR;
            end
          end
          ST_BUS_WR: begin
            tx_data_o <= ACK_BYTE;
            state     <= ST_TX_B1;
          end
          ST_BUS_RD: begin
            tx_data_o <= ip2bus_data_i[15:8];
            rdata_lo  <= ip2bus_data_i[7:0];
            state     <= ST_TX_B0;
          end
          ST_TX_B0: begin
            if (tx_fire) begin
              tx_data_o <= rdata_lo;
              state     <= ST_TX_B1;
            end
          end
          ST_TX_B1: begin
            if (tx_fire) begin
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Directed testbench for uart_bus_bridge. A negedge monitor counts strobes and
// error pulses and records transmitted bytes; each test task checks inline.
module tb_uart_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        rd_ce;
  logic        wr_ce;
  logic [15:0] ip_data;
  logic [15:0] rd_resp;
  logic        frame_err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int          wr_count  = 0;
  int          rd_count  = 0;
  int          err_count = 0;
  int          both_seen = 0;
  logic [15:0] wr_addr_seen;
  logic [15:0] wr_data_seen;
  logic [15:0] rd_addr_seen;
  logic [7:0]  txq[$];

  always #5 clk = ~clk;

  // Responder: read data is only meaningful while rd_ce is high.
  assign ip_data = rd_ce ? rd_resp : 16'h0000;

  uart_bus_bridge #(
    .TIMEOUT_CYCLES (16'd100),
    .ACK_BYTE       (8'hAA),
    .ERR_BYTE       (8'hEE)
  ) dut (
    .bus2ip_clk     (clk),
    .bus2ip_rst_n   (rst_n),
    .rx_data_i      (rx_data),
    .rx_valid_i     (rx_valid),
    .rx_ready_o     (rx_ready),
    .tx_data_o      (tx_data),
    .tx_valid_o     (tx_valid),
    .tx_ready_i     (tx_ready),
    .bus2ip_addr_o  (addr),
    .bus2ip_data_o  (wdata),
    .bus2ip_rd_ce_o (rd_ce),
    .bus2ip_wr_ce_o (wr_ce),
    .ip2bus_data_i  (ip_data),
    .frame_err_o    (frame_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: inputs change only just after posedge, so negedge values hold
  // until the next active edge.
  always @(negedge clk) begin
    if (wr_ce) begin
      wr_count     <= wr_count + 1;
      wr_addr_seen <= addr;
      wr_data_seen <= wdata;
    end
    if (rd_ce) begin
      rd_count     <= rd_count + 1;
      rd_addr_seen <= addr;
    end
    if (wr_ce && rd_ce) both_seen <= both_seen + 1;
    if (frame_err) err_count <= err_count + 1;
    if (tx_valid && tx_ready) txq.push_back(tx_data);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one byte and return just after the edge that consumed it.
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok       = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL rx_accept: byte %h not consumed within 50 cycles", b);
    end
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rx_ready && !tx_valid) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: block did not return to idle within 50 cycles", name);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    rd_resp  = 16'h0000;
    tick(3);
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", addr); end
    checks++; if (wdata !== 16'h0000) begin errors++; $display("FAIL reset_wdata: got %h expected 0000", wdata); end
    checks++; if ({rd_ce, wr_ce, frame_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {rd_ce, wr_ce, frame_err}); end
    rst_n = 1'b1;
    tick(1);
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL post_reset_rx_ready: got %b expected 1", rx_ready); end
  endtask

  task automatic test_write();
    int t0;
    int w0;
    w0 = wr_count;
    txq.delete();
    t0 = cyc;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h2C);
    rx_valid = 1'b0;
    checks++; if (cyc - t0 !== 5) begin errors++; $display("FAIL wr_back_to_back: took %0d cycles expected 5", cyc - t0); end
    checks++; if ({wr_ce, rd_ce} !== 2'b10) begin errors++; $display("FAIL wr_strobe: got wr/rd %b expected 10", {wr_ce, rd_ce}); end
    checks++; if (addr !== 16'h0000) begin errors++; $display("FAIL wr_addr: got %h expected 0000", addr); end
    checks++; if (wdata !== 16'h012C) begin errors++; $display("FAIL wr_data: got %h expected 012C", wdata); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL wr_bus_rx_ready: got %b expected 0", rx_ready); end
    tick(1);
    checks++; if (wr_ce !== 1'b0) begin errors++; $display("FAIL wr_strobe_width: got %b expected 0", wr_ce); end
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'hAA}) begin errors++; $display("FAIL wr_ack: got valid=%b data=%h expected 1 AA", tx_valid, tx_data); end
    tick(1);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL wr_resp_len: tx_valid got %b expected 0", tx_valid); end
    checks++; if (wr_count - w0 !== 1) begin errors++; $display("FAIL wr_count: got %0d expected 1", wr_count - w0); end
    checks++; if (txq.size() !== 1 || txq[0] !== 8'hAA) begin errors++; $display("FAIL wr_txq: got %0d bytes expected 1 byte AA", txq.size()); end
  endtask

  task automatic test_read();
    int r0;
    r0 = rd_count;
    txq.delete();
    rd_resp = 16'h0180;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h03);
    rx_valid = 1'b0;
    checks++; if ({rd_ce, wr_ce} !== 2'b10) begin errors++; $display("FAIL rd_strobe: got rd/wr %b expected 10", {rd_ce, wr_ce}); end
    checks++; if (addr !== 16'h0003) begin errors++; $display("FAIL rd_addr: got %h expected 0003", addr); end
    tick(1);
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h01}) begin errors++; $display("FAIL rd_byte0: got valid=%b data=%h expected 1 01", tx_valid, tx_data); end
    tick(1);
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h80}) begin errors++; $display("FAIL rd_byte1: got valid=%b data=%h expected 1 80", tx_valid, tx_data); end
    tick(1);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rd_resp_len: tx_valid got %b expected 0", tx_valid); end
    checks++; if (rd_count - r0 !== 1) begin errors++; $display("FAIL rd_count: got %0d expected 1", rd_count - r0); end
    checks++; if (txq.size() !== 2 || txq[0] !== 8'h01 || txq[1] !== 8'h80) begin errors++; $display("FAIL rd_txq: got %0d bytes expected 01 80", txq.size()); end
  endtask

  task automatic test_backpressure();
    int r0;
    int bad;
    r0 = rd_count;
    bad = 0;
    txq.delete();
    tx_ready = 1'b0;
    rd_resp  = 16'h0180;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
    rx_valid = 1'b0;
    tick(1);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h01 || rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got valid=%b data=%h rx_ready=%b expected 1 01 0", i, tx_valid, tx_data, rx_ready);
      end
      tick(1);
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    wait_idle("bp");
    checks++; if (txq.size() !== 2 || txq[0] !== 8'h01 || txq[1] !== 8'h80) begin errors++; $display("FAIL bp_txq: got %0d bytes expected 01 80", txq.size()); end
    checks++; if (rd_count - r0 !== 1 || rd_addr_seen !== 16'h0005) begin errors++; $display("FAIL bp_rd: got %0d reads addr %h expected 1 at 0005", rd_count - r0, rd_addr_seen); end
  endtask

  task automatic test_unknown();
    int s0;
    int e0;
    s0 = wr_count + rd_count;
    e0 = err_count;
    txq.delete();
    send_byte(8'h7F);
    rx_valid = 1'b0;
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL unk_err: got %b expected 1", frame_err); end
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'hEE}) begin errors++; $display("FAIL unk_resp: got valid=%b data=%h expected 1 EE", tx_valid, tx_data); end
    tick(1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL unk_err_width: got %b expected 0", frame_err); end
    wait_idle("unk");
    checks++; if (wr_count + rd_count !== s0) begin errors++; $display("FAIL unk_strobe: got %0d strobes expected 0", wr_count + rd_count - s0); end
    checks++; if (err_count - e0 !== 1) begin errors++; $display("FAIL unk_err_count: got %0d expected 1", err_count - e0); end
    checks++; if (txq.size() !== 1 || txq[0] !== 8'hEE) begin errors++; $display("FAIL unk_txq: got %0d bytes expected EE", txq.size()); end
    txq.delete();
    rd_resp = 16'h1234;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h07);
    rx_valid = 1'b0;
    wait_idle("unk_rd");
    checks++; if (txq.size() !== 2 || txq[0] !== 8'h12 || txq[1] !== 8'h34) begin errors++; $display("FAIL unk_followup: got %0d bytes expected 12 34", txq.size()); end
    checks++; if (rd_addr_seen !== 16'h0007) begin errors++; $display("FAIL unk_followup_addr: got %h expected 0007", rd_addr_seen); end
  endtask

  task automatic test_timeout();
    int s0;
    int e0;
    logic seen;
    s0 = wr_count + rd_count;
    e0 = err_count;
    txq.delete();
`ifdef UART_BRIDGE_TIMEOUT_EN
    send_byte(8'h01); send_byte(8'h00);
    rx_valid = 1'b0;
    tick(99);
    checks++; if (err_count !== e0) begin errors++; $display("FAIL tmo_early: got %0d errors before 100 idle cycles expected 0", err_count - e0); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (err_count != e0) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL tmo_err: got no frame_err expected one pulse"); end
    checks++; if (err_count - e0 !== 1) begin errors++; $display("FAIL tmo_err_count: got %0d expected 1", err_count - e0); end
    checks++; if (wr_count + rd_count !== s0 || txq.size() !== 0) begin errors++; $display("FAIL tmo_discard: got %0d strobes %0d tx expected 0 0", wr_count + rd_count - s0, txq.size()); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL tmo_idle: rx_ready got %b expected 1", rx_ready); end
    rd_resp = 16'hBA0D;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    rx_valid = 1'b0;
    wait_idle("tmo_rd");
    checks++; if (txq.size() !== 2 || txq[0] !== 8'hBA || txq[1] !== 8'h0D) begin errors++; $display("FAIL tmo_followup: got %0d bytes expected BA 0D", txq.size()); end
`else
    seen = 1'b0;
    send_byte(8'h01); send_byte(8'hAB);
    rx_valid = 1'b0;
    tick(200);
    checks++; if (err_count !== e0) begin errors++; $display("FAIL wait_no_err: got %0d errors expected 0", err_count - e0); end
    checks++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL wait_state: rx_ready=%b tx_valid=%b expected 1 0", rx_ready, tx_valid); end
    send_byte(8'hCD); send_byte(8'h56); send_byte(8'h78);
    rx_valid = 1'b0;
    wait_idle("wait_wr");
    seen = (wr_count - (s0 - rd_count)) == 1;
    checks++; if (seen !== 1'b1 || wr_addr_seen !== 16'hABCD || wr_data_seen !== 16'h5678) begin errors++; $display("FAIL wait_wr: got addr %h data %h expected ABCD 5678 once", wr_addr_seen, wr_data_seen); end
    checks++; if (txq.size() !== 1 || txq[0] !== 8'hAA) begin errors++; $display("FAIL wait_ack: got %0d bytes expected AA", txq.size()); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int w0;
    w0 = wr_count;
    txq.delete();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    rx_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({rx_ready, tx_valid, rd_ce, wr_ce, frame_err} !== 5'b00000) begin errors++; $display("FAIL mid_rst_ctl: got %b expected 00000", {rx_ready, tx_valid, rd_ce, wr_ce, frame_err}); end
    checks++; if ({addr, wdata, tx_data} !== 40'h0) begin errors++; $display("FAIL mid_rst_regs: got addr %h data %h tx %h expected 0 0 0", addr, wdata, tx_data); end
    tick(2);
    rst_n = 1'b1;
    tick(10);
    checks++; if (wr_count !== w0 || txq.size() !== 0) begin errors++; $display("FAIL mid_rst_abort: got %0d writes %0d tx expected 0 0", wr_count - w0, txq.size()); end
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00); send_byte(8'h42);
    rx_valid = 1'b0;
    wait_idle("mid_rst_wr");
    checks++; if (wr_count - w0 !== 1 || wr_addr_seen !== 16'h0010 || wr_data_seen !== 16'h0042) begin errors++; $display("FAIL mid_rst_followup: got %0d writes addr %h data %h expected 1 0010 0042", wr_count - w0, wr_addr_seen, wr_data_seen); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_unknown();
    test_timeout();
    test_reset_mid_frame();
    checks++; if (both_seen !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles with both strobes expected 0", both_seen); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
